// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative RV32M multiply/divide unit. One operation is accepted
//             per start pulse in IDLE; the result appears on C with a
//             one-cycle done pulse a fixed WIDTH+2 cycles later, independent
//             of the operand values.
//  Ports    : clk   - rising-edge clock
//             rst   - synchronous active-high reset
//             start - request pulse, sampled only in IDLE
//             op    - funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//             A     - rs1 (multiplicand / dividend)
//             B     - rs2 (multiplier / divisor)
//             busy  - high in CALC and FIX
//             done  - one-cycle pulse, C valid in that cycle
//             C     - result, held until the next done
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;          // original A, returned by REM/x/0
    logic               neg_a_q, neg_a_d;  // A is signed and negative
    logic               neg_b_q, neg_b_d;  // B is signed and negative
    logic               bzero_q, bzero_d;
    logic               ovf_q, ovf_d;
    logic [5:0]         cnt_q, cnt_d;
    // opnd: multiplicand (multiply) or divisor (divide) magnitude
    // hi  : upper product half (multiply) or partial remainder (divide)
    // lo  : multiplier shifting out (multiply) or dividend->quotient (divide)
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   c_q, c_d;

    // ------------------------------------------------------------------
    // Operand decode at the start pulse
    // ------------------------------------------------------------------
    logic               a_signed_in, b_signed_in;
    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;

    always_comb begin
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
        case (op)
            OP_MULH:   begin a_signed_in = 1'b1; b_signed_in = 1'b1; end
            OP_MULHSU: begin a_signed_in = 1'b1; b_signed_in = 1'b0; end
            OP_DIV:    begin a_signed_in = 1'b1; b_signed_in = 1'b1; end
            OP_REM:    begin a_signed_in = 1'b1; b_signed_in = 1'b1; end
            default:   begin a_signed_in = 1'b0; b_signed_in = 1'b0; end
        endcase
        a_neg_in = a_signed_in & A[WIDTH-1];
        b_neg_in = b_signed_in & B[WIDTH-1];
        // The magnitude of the most-negative value is 2^(WIDTH-1), which
        // still fits unsigned in WIDTH bits, so plain negation is exact.
        a_mag_in = a_neg_in ? -A : A;
        b_mag_in = b_neg_in ? -B : B;
    end

    // ------------------------------------------------------------------
    // One iteration step of each algorithm
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_trial;

    always_comb begin
        mul_addend = lo_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
        // Remainder stays below the divisor, so after the shift it needs
        // one extra bit; when the trial succeeds its true value is below
        // the divisor and the low WIDTH bits of the difference are exact.
        div_shift  = {hi_q, lo_q[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, opnd_q});
        div_trial  = div_shift[WIDTH-1:0] - opnd_q;
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection (used in FIX)
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   result;

    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
        quot_fix = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem_fix  = neg_a_q ? -hi_q : hi_q;   // remainder follows dividend
        case (op_q)
            OP_MUL:                       result = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                if (bzero_q)    result = '1;
                else if (ovf_q) result = MIN_NEG;
                else            result = quot_fix;
            end
            default: begin // REM, REMU
                if (bzero_q)    result = a_q;
                else if (ovf_q) result = '0;
                else            result = rem_fix;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bzero_d = bzero_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        c_d     = c_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = A;
                    neg_a_d = a_neg_in;
                    neg_b_d = b_neg_in;
                    bzero_d = (B == '0);
                    ovf_d   = ((op == OP_DIV) || (op == OP_REM)) &&
                              (A == MIN_NEG) && (B == '1);
                    cnt_d   = '0;
                    hi_d    = '0;
                    if (op[2]) begin
                        opnd_d = b_mag_in;   // divisor
                        lo_d   = a_mag_in;   // dividend
                    end else begin
                        opnd_d = a_mag_in;   // multiplicand
                        lo_d   = b_mag_in;   // multiplier
                    end
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                if (op_q[2]) begin
                    hi_d = div_ge ? div_trial : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                c_d     = result;
                state_d = S_DONE;
            end

            default: begin // S_DONE
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bzero_q <= bzero_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign C    = c_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Directed self-checking bench for mdu_iter with hand-computed
//             expected results, latency and protocol checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int WIDTH  = 32;
    localparam int PERIOD = 10;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] C;

    int     n_pass;
    int     n_total;
    longint t_done;
    longint t_prev;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .C     (C)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one operation and follow it to done. If glitch > 0, a second
    // start with different operands is driven in that cycle of the run.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int glitch);
        int lat;
        int busy_n;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        lat = 1; busy_n = 0;
        while (!done && lat < 100) begin
            if (lat == glitch) begin
                start = 1'b1; op = OP_DIVU; A = $urandom; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        t_done = $time;
        check({tag, " C"},       C,      exp);
        check({tag, " latency"}, lat,    34);
        check({tag, " busy"},    busy_n, 33);
        check({tag, " no busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, " hold"},    C,      exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        n_pass = 0; n_total = 0;
        rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset C",    C,             32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Multiply
        run_op("MUL 7*-3",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op("MULH",        OP_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op("MULHU",       OP_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 0);
        run_op("MULHSU",      OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("MULHU max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("MUL lo",      OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 0);

        // Divide
        run_op("DIV -7/2",    OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run_op("REM -7%2",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run_op("DIVU",        OP_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 0);
        run_op("REMU",        OP_REMU,   32'hFFFFFFF9, 32'd2,        32'h00000001, 0);
        run_op("DIV 100/-7",  OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0);
        run_op("REM 100%-7",  OP_REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 0);

        // Special cases
        run_op("DIV /0",      OP_DIV,    32'h00001234, 32'd0,        32'hFFFFFFFF, 0);
        run_op("DIVU /0",     OP_DIVU,   32'h00001234, 32'd0,        32'hFFFFFFFF, 0);
        run_op("REM /0",      OP_REM,    32'h00001234, 32'd0,        32'h00001234, 0);
        run_op("REMU /0",     OP_REMU,   32'h00001234, 32'd0,        32'h00001234, 0);
        run_op("DIV ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("REM ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

        // start during CALC is ignored
        run_op("MUL glitch",  OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 5);

        // Back-to-back: start in the cycle after done, spacing 35
        t_prev = t_done;
        run_op("DIVU b2b",    OP_DIVU,   32'd100,      32'd7,        32'd14,       0);
        check("done spacing", 32'(int'((t_done - t_prev) / PERIOD)), 32'd35);

        // Reset at CALC cycle 10 aborts the operation
        @(negedge clk);
        start = 1'b1; op = OP_MUL; A = 32'd7; B = 32'hFFFFFFFD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort C",    C,             32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        check("abort no done", dn, 0);

        run_op("after abort", OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit, paired with the single-cycle ALU.
- The control unit issues an operation with a one-cycle start pulse.
- The unit computes over a fixed number of cycles and returns the result with a one-cycle done pulse.
- The datapath stalls PC/register-file writeback while busy is high.

Parameters:
- WIDTH, 32: operand/result width. The iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only in IDLE
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  input  WIDTH  rs1 operand (dividend / multiplicand)
- B  input  WIDTH  rs2 operand (divisor / multiplier)
- busy  output  1  high in CALC and FIX states
- done  output  1  one-cycle pulse; C is valid in that cycle
- C  output  WIDTH  result; holds its value until the next done

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high.
  - On rst: state=IDLE, busy=0, done=0, C=0, all internal registers cleared.
  - rst mid-operation aborts the operation with no done pulse.
- State machine: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: if start=1, latch op, A and B. Record the operand signs from op: A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM. Load the magnitudes, clear the 6-bit iteration counter, go to CALC.
  - CALC: exactly WIDTH cycles, one iteration per cycle. Counter reaches WIDTH-1, then go to FIX.
  - FIX: one cycle. Apply sign correction and special cases, register the result into C, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency:
  - start sampled at edge t gives busy high in cycles t+1..t+WIDTH+1.
  - done is high in cycle t+WIDTH+2 (34 for WIDTH=32).
  - Latency is fixed and data-independent, including special cases.
- start handling: start while busy or in DONE is ignored, with no queuing. A and B changes after the sample are ignored.
- Multiply (shift-add on magnitudes, 2*WIDTH-bit accumulator):
  - Each CALC cycle: if multiplier LSB=1, add the multiplicand into the upper half; then shift the {acc, multiplier} pair right by 1.
  - FIX: negate the 2W product if the operand signs differ, considering only signed operands.
  - Select result: MUL = low W bits; MULH, MULHSU, MULHU = high W bits.
- Divide (restoring, on magnitudes):
  - Each CALC cycle: shift {rem, quot} left by 1; trial = rem - divisor. If trial >= 0, rem = trial and quot LSB = 1.
  - FIX: quotient negated if the signs differ (signed ops). Remainder takes the dividend's sign.
- Special cases, applied in FIX and overriding the iterative result:
  - Divide by zero: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Width: all magnitude arithmetic is unsigned, W+1 bits for the divider trial subtraction. The most-negative value's magnitude is 2^(W-1) and is represented correctly in W bits unsigned.
- C changes only in FIX (and on rst). done never coincides with busy.

Test Plan:
- MUL with A=7, B=-3 (0xFFFFFFFD) -> C=0xFFFFFFEB. done exactly 34 cycles after start; busy high for 33 cycles.
- MULH/MULHU/MULHSU with A=0x80000000, B=0xFFFFFFFF -> MULH=0x00000000, MULHU=0x7FFFFFFF, MULHSU=0x80000000.
- DIV/REM with A=-7, B=2 -> DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1). DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Divide by zero A=0x1234, B=0: DIV and DIVU -> 0xFFFFFFFF, REM and REMU -> 0x1234. Overflow A=0x80000000, B=-1: DIV -> 0x80000000, REM -> 0. Latency is still 34.
- Protocol: start re-asserted during CALC with new A/B -> ignored, original result returned. start in the cycle after done -> accepted normally. Back-to-back operations give done spacing of 35 cycles.
- Reset: rst asserted at CALC cycle 10 -> next cycle busy=0, done=0, C=0, and no done pulse follows. A new start afterwards completes correctly.
